// File: rtl/pulse_multiplier_pkg.sv
// Shared types and constants for the pulse multiplier and its front end.
package pulse_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Shortest period that still leaves at least one idle clock between output pulses.
    function automatic int min_period(input int mult);
        return 2 * mult;
    endfunction

    // Saturation value of a period counter of the given width.
    function automatic longint unsigned counter_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Two-flop synchronizer for an asynchronous pulse train followed by a
// registered rising-edge detector; rise_strobe is high for one clock per edge.
module pulse_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic rise_strobe
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic rise_reg;

    // Synchronize, keep the previous synchronized level and register the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= pulse_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            rise_reg  <= sync2_reg & ~prev_reg;
        end
    end

    assign rise_strobe = rise_reg;

endmodule

// File: rtl/pulse_multiplier.sv
// Frequency multiplier: measures the input pulse period in clocks and
// regenerates MULT evenly spaced single-cycle pulses per period using a
// Bresenham accumulator (acc += MULT, emit and subtract P when acc >= P).
module pulse_multiplier
    import pulse_multiplier_pkg::*;
#(
    parameter int MULT  = 4,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             pulse_out,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(counter_max(CNT_W));
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(min_period(MULT));
    localparam logic [CNT_W:0]   ACC_STEP  = (CNT_W + 1)'(MULT);
    localparam int               GEN_W     = $clog2(MULT) + 1;
    localparam logic [GEN_W-1:0] GEN_LIMIT = GEN_W'(MULT - 1);

    state_t             state_reg;
    state_t             state_next;
    logic               rise_strobe;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W:0]     acc_reg;
    logic [GEN_W-1:0]   gen_cnt_reg;
    logic               pulse_reg;
    logic               timeout_reg;
    logic               pulse_next;

    logic               saturated;
    logic               long_enough;
    logic [CNT_W:0]     acc_sum;
    logic               acc_hit;
    logic               budget_left;

    pulse_edge_sync u_edge_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (pulse_in),
        .rise_strobe (rise_strobe)
    );

    // An edge always wins over saturation, so a period of exactly CNT_MAX is still measured.
    assign saturated   = (state_reg != IDLE) && !rise_strobe && (count_reg == CNT_MAX);
    assign long_enough = (count_reg >= MIN_P);
    assign acc_sum     = acc_reg + ACC_STEP;
    assign acc_hit     = (acc_sum >= {1'b0, period_reg});
    assign budget_left = (gen_cnt_reg < GEN_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: disable and counter saturation both fall back to IDLE.
    always_comb begin
        state_next = state_reg;
        if (!enable || saturated) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (rise_strobe) state_next = ACQUIRE;
                ACQUIRE: if (rise_strobe && long_enough) state_next = LOCKED;
                LOCKED:  if (rise_strobe && !long_enough) state_next = ACQUIRE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: edge pulse on a locking/locked edge, otherwise budgeted accumulator pulses.
    always_comb begin
        locked     = (state_reg == LOCKED);
        pulse_next = 1'b0;
        if (enable) begin
            if (rise_strobe) begin
                pulse_next = (state_reg == LOCKED) || ((state_reg == ACQUIRE) && long_enough);
            end else if ((state_reg == LOCKED) && acc_hit && budget_left) begin
                pulse_next = 1'b1;
            end
        end
    end

    // Period counter, measured period, accumulator and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            period_reg  <= '0;
            acc_reg     <= '0;
            gen_cnt_reg <= '0;
            pulse_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            pulse_reg   <= pulse_next;
            timeout_reg <= saturated;

            // IDLE holds the counter at zero: nothing is being measured, so it cannot time out.
            if (rise_strobe) begin
                count_reg <= CNT_W'(1);
            end else if (state_reg == IDLE) begin
                count_reg <= '0;
            end else if (count_reg != CNT_MAX) begin
                count_reg <= count_reg + CNT_W'(1);
            end

            // The first edge from IDLE only starts a measurement; there is no period yet.
            if (rise_strobe && (state_reg != IDLE)) begin
                period_reg <= count_reg;
            end

            // Over-budget hits still wrap the accumulator so it stays below P.
            if (rise_strobe) begin
                acc_reg     <= '0;
                gen_cnt_reg <= '0;
            end else if (state_reg == LOCKED) begin
                if (acc_hit) begin
                    acc_reg <= acc_sum - {1'b0, period_reg};
                    if (budget_left) begin
                        gen_cnt_reg <= gen_cnt_reg + GEN_W'(1);
                    end
                end else begin
                    acc_reg <= acc_sum;
                end
            end
        end
    end

    assign pulse_out = pulse_reg;
    assign period    = period_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_pulse_multiplier.sv
// Directed bench for pulse_multiplier (MULT=4, CNT_W=8).
module tb_pulse_multiplier;

    localparam int MULT  = 4;
    localparam int CNT_W = 8;
    // Input rise driven when the cycle counter reads r is seen as an edge pulse at r+4
    // (sampled on the first clock edge r+1, output asserted three edges later).
    localparam int LAT   = 4;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             pulse_in;
    logic             pulse_out;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             timeout;

    int cyc = 0;
    int pulse_log[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_a[4];

    pulse_multiplier #(.MULT(MULT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pulse_in  (pulse_in),
        .pulse_out (pulse_out),
        .locked    (locked),
        .period    (period),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pulse_out === 1'b1) pulse_log.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Compare pulses logged in [lo,hi) against expected offsets from lo.
    task automatic check_window(input string tag, input int lo, input int hi,
                                input int exp_off[4], input int n);
        int got[$];
        foreach (pulse_log[i]) begin
            if (pulse_log[i] >= lo && pulse_log[i] < hi) got.push_back(pulse_log[i] - lo);
        end
        check($sformatf("%s_count", tag), got.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_off%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_off[i]);
        end
    endtask

    task automatic run_period(input int p, output int rise);
        rise = cyc;
        pulse_in = 1'b1;
        tick(p / 2);
        pulse_in = 1'b0;
        tick(p - p / 2);
    endtask

    initial begin
        int r0, r1, r2, r3, r4, r5, r6, r7, r8;
        int ra, rb, rc, rd, re, rf, rg, rh, ri, rj;

        // Reset state
        rst_n = 1'b0; enable = 1'b0; pulse_in = 1'b0;
        tick(3);
        check("rst_pulse_out", pulse_out, 0);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1; enable = 1'b1;
        tick(2);

        // First edge: acquire only, no output
        run_period(100, r0);
        check("first_edge_locked", locked, 0);
        check_window("first_edge", r0, r0 + 100, exp_a, 0);

        // Second edge: lock, latency of the edge pulse
        r1 = cyc;
        pulse_in = 1'b1;
        tick(3);
        check("latency_early", pulse_out, 0);
        tick(1);
        check("latency_pulse", pulse_out, 1);
        check("lock_after_2nd", locked, 1);
        tick(46);
        pulse_in = 1'b0;
        tick(50);
        check("period_100", period, 100);

        // Steady 100, then 100 -> 60, then 60 -> 10
        run_period(100, r2);
        run_period(60, r3);
        run_period(60, r4);
        run_period(10, r5);
        run_period(10, r6);
        run_period(10, r7);
        run_period(10, r8);
        check("period_10", period, 10);
        exp_a = '{0, 25, 50, 75};
        check_window("p100_a", r1 + LAT, r2 + LAT, exp_a, 4);
        check_window("p100_b", r2 + LAT, r3 + LAT, exp_a, 4);
        exp_a = '{0, 25, 50, 0};
        check_window("short60", r3 + LAT, r4 + LAT, exp_a, 3);
        exp_a = '{0, 15, 30, 45};
        check_window("p60", r4 + LAT, r5 + LAT, exp_a, 4);
        exp_a = '{0, 0, 0, 0};
        check_window("short10", r5 + LAT, r6 + LAT, exp_a, 1);
        exp_a = '{0, 3, 5, 8};
        check_window("p10_a", r6 + LAT, r7 + LAT, exp_a, 4);
        check_window("p10_b", r7 + LAT, r8 + LAT, exp_a, 4);

        // enable low for one cycle forces IDLE
        enable = 1'b0;
        tick(1);
        check("dis_locked", locked, 0);
        check("dis_pulse_out", pulse_out, 0);
        enable = 1'b1;

        // Period 6 (< 2*MULT): stays in ACQUIRE, no output
        run_period(6, ra);
        run_period(6, rb);
        run_period(6, rc);
        check("p6_locked", locked, 0);
        check("p6_period", period, 6);
        check_window("p6", ra, cyc + 1, exp_a, 0);

        // Lock at 100, then stop the input: timeout when counter hits 255
        run_period(100, rd);
        run_period(100, re);
        check("pre_to_locked", locked, 1);
        tick(158);
        check("to_early", timeout, 0);
        check("to_early_locked", locked, 1);
        tick(1);
        check("to_strobe", timeout, 1);
        check("to_locked", locked, 0);
        check("to_pulse_out", pulse_out, 0);
        tick(1);
        check("to_one_cycle", timeout, 0);

        // Two fresh edges needed to relock after timeout
        run_period(100, rf);
        check("post_to_locked", locked, 0);
        check_window("post_to_first", rf, rf + 100, exp_a, 0);
        run_period(100, rg);
        check("relock_locked", locked, 1);
        check("relock_period", period, 100);
        exp_a = '{0, 25, 50, 75};
        check_window("relock", rg + LAT, rg + LAT + 100, exp_a, 4);

        // Asynchronous reset mid-LOCKED, while a pulse is high
        rh = cyc;
        pulse_in = 1'b1;
        tick(29);
        check("pre_rst_pulse", pulse_out, 1);
        check("pre_rst_locked", locked, 1);
        #2;
        rst_n = 1'b0;
        pulse_in = 1'b0;
        #1;
        check("arst_pulse_out", pulse_out, 0);
        check("arst_locked", locked, 0);
        check("arst_period", period, 0);
        check("arst_timeout", timeout, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Relock after reset needs two edges
        run_period(100, ri);
        check("rst_relock_first", locked, 0);
        exp_a = '{0, 0, 0, 0};
        check_window("rst_first", ri, ri + 100, exp_a, 0);
        run_period(100, rj);
        check("rst_relock_locked", locked, 1);
        check("rst_relock_period", period, 100);
        exp_a = '{0, 25, 50, 75};
        check_window("rst_relock", rj + LAT, rj + LAT + 100, exp_a, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
